// File: rtl/envelope_generator_mc_if.sv
// Event request, level/step configuration and sample stream of the multi-voice envelope generator.
// master drives events and levels; slave is the generator itself.
interface envelope_generator_mc_if #(
  parameter int VOICES = 8,
  parameter int VAL_W  = 18,
  parameter int VIDX_W = $clog2(VOICES)
);
  logic              ev_valid;
  logic              ev_ready;
  logic [VIDX_W-1:0] ev_voice;
  logic              ev_on;
  logic [VAL_W-1:0]  level_start;
  logic [VAL_W-1:0]  level_peak;
  logic [VAL_W-1:0]  level_sustain;
  logic [VAL_W-1:0]  level_floor;
  logic [VAL_W-1:0]  attack_step;
  logic [VAL_W-1:0]  decay_step;
  logic [VAL_W-1:0]  release_step;
  logic              out_valid;
  logic [VIDX_W-1:0] out_voice;
  logic [VAL_W-1:0]  out_value;
  logic [VOICES-1:0] busy;
  logic              done;
  logic [VIDX_W-1:0] done_voice;

  modport master (
    output ev_valid, ev_voice, ev_on,
    output level_start, level_peak, level_sustain, level_floor,
    output attack_step, decay_step, release_step,
    input  ev_ready, out_valid, out_voice, out_value, busy, done, done_voice
  );

  modport slave (
    input  ev_valid, ev_voice, ev_on,
    input  level_start, level_peak, level_sustain, level_floor,
    input  attack_step, decay_step, release_step,
    output ev_ready, out_valid, out_voice, out_value, busy, done, done_voice
  );
endinterface

// File: rtl/envelope_generator_mc.sv
// Multi-voice ADSR envelope generator: one shared update datapath visits each voice round-robin,
// emitting a registered (voice, value) sample one cycle after that voice is processed.
module envelope_generator_mc #(
  parameter int VOICES = 8,
  parameter int VAL_W  = 18,
  parameter int VIDX_W = $clog2(VOICES)
) (
  input  logic                    clk,
  input  logic                    rst,
  envelope_generator_mc_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t            st_q   [VOICES];
  logic [VAL_W-1:0]  val_q  [VOICES];
  logic [VOICES-1:0] pend_vld_q;
  logic [VOICES-1:0] pend_on_q;
  logic [VIDX_W-1:0] ptr_q;

  logic              ev_ready_q;
  logic              out_valid_q;
  logic [VIDX_W-1:0] out_voice_q;
  logic [VAL_W-1:0]  out_value_q;
  logic [VOICES-1:0] busy_q;
  logic              done_q;
  logic [VIDX_W-1:0] done_voice_q;

  state_t            cur_st;
  logic [VAL_W-1:0]  cur_val;
  logic              pv;
  logic              po;
  state_t            nxt_st;
  logic [VAL_W-1:0]  nxt_val;
  logic              fin;
  logic              ev_acc;

  // Slew v toward t by s, clamped at t; the extra bit keeps the sum from wrapping.
  function automatic logic [VAL_W-1:0] toward(input logic [VAL_W-1:0] v,
                                              input logic [VAL_W-1:0] t,
                                              input logic [VAL_W-1:0] s);
    logic [VAL_W:0] sum;
    logic [VAL_W:0] gap;
    sum = {1'b0, v} + {1'b0, s};
    gap = {1'b0, v} - {1'b0, t};
    if (v < t)
      toward = (sum > {1'b0, t}) ? t : sum[VAL_W-1:0];
    else if (v > t)
      toward = (gap <= {1'b0, s}) ? t : (v - s);
    else
      toward = t;
  endfunction

  assign ev_acc = bus.ev_valid & ev_ready_q;

  always_comb begin
    cur_st  = st_q[ptr_q];
    cur_val = val_q[ptr_q];
    pv      = pend_vld_q[ptr_q];
    po      = pend_on_q[ptr_q];
    nxt_st  = cur_st;
    nxt_val = cur_val;
    fin     = 1'b0;
    case (cur_st)
      S_IDLE: begin
        nxt_val = bus.level_start;
        if (pv && po) nxt_st = S_ATTACK;
      end
      S_ATTACK: begin
        if (pv) begin
          if (!po) nxt_st = S_RELEASE;
        end else begin
          nxt_val = toward(cur_val, bus.level_peak, bus.attack_step);
          if (nxt_val == bus.level_peak) nxt_st = S_DECAY;
        end
      end
      S_DECAY: begin
        if (pv) begin
          nxt_st = po ? S_ATTACK : S_RELEASE;
        end else begin
          nxt_val = toward(cur_val, bus.level_sustain, bus.decay_step);
          if (nxt_val == bus.level_sustain) nxt_st = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        nxt_val = bus.level_sustain;
        if (pv) nxt_st = po ? S_ATTACK : S_RELEASE;
      end
      S_RELEASE: begin
        // A note_on here resumes the attack from wherever the release has got to.
        if (pv && po) begin
          nxt_st = S_ATTACK;
        end else begin
          nxt_val = toward(cur_val, bus.level_floor, bus.release_step);
          if (nxt_val == bus.level_floor) begin
            nxt_st = S_IDLE;
            fin    = 1'b1;
          end
        end
      end
      default: nxt_st = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        st_q[i]  <= S_IDLE;
        val_q[i] <= '0;
      end
      pend_vld_q   <= '0;
      pend_on_q    <= '0;
      ptr_q        <= '0;
      ev_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_voice_q  <= '0;
      out_value_q  <= '0;
      busy_q       <= '0;
      done_q       <= 1'b0;
      done_voice_q <= '0;
    end else begin
      st_q[ptr_q]       <= nxt_st;
      val_q[ptr_q]      <= nxt_val;
      // A same-cycle event to the voice being processed survives for its next visit.
      pend_vld_q[ptr_q] <= 1'b0;
      if (ev_acc) begin
        pend_vld_q[bus.ev_voice] <= 1'b1;
        pend_on_q[bus.ev_voice]  <= bus.ev_on;
      end
      ptr_q         <= ptr_q + VIDX_W'(1);
      ev_ready_q    <= 1'b1;
      out_valid_q   <= 1'b1;
      out_voice_q   <= ptr_q;
      out_value_q   <= nxt_val;
      busy_q[ptr_q] <= (nxt_st != S_IDLE);
      done_q        <= fin;
      if (fin) done_voice_q <= ptr_q;
    end
  end

  assign bus.ev_ready   = ev_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_voice  = out_voice_q;
  assign bus.out_value  = out_value_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_voice = done_voice_q;

endmodule

// File: tb/tb_envelope_generator_mc.sv
// Scenario bench for envelope_generator_mc: a reference model pushes expected samples per cycle,
// scenario tasks add fixed-value checks on the envelope shapes.
module tb_envelope_generator_mc;
  localparam int VOICES = 4;
  localparam int VAL_W  = 18;
  localparam int VIDX_W = 2;
  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  typedef struct packed {
    logic              vld;
    logic [VIDX_W-1:0] voice;
    logic [VAL_W-1:0]  value;
    logic [VOICES-1:0] busy;
    logic              done;
    logic [VIDX_W-1:0] dv;
  } samp_t;

  logic clk;
  logic rst;

  envelope_generator_mc_if #(.VOICES(VOICES), .VAL_W(VAL_W), .VIDX_W(VIDX_W)) bus ();

  envelope_generator_mc #(.VOICES(VOICES), .VAL_W(VAL_W), .VIDX_W(VIDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_cmp = 0;
  int                n_err = 0;
  int                m_st  [VOICES];
  int                m_val [VOICES];
  bit                m_pv  [VOICES];
  bit                m_po  [VOICES];
  int                m_p;
  int                m_dv;
  bit                m_rdy;
  logic [VOICES-1:0] m_busy;
  samp_t             exp_q [$];

  function automatic int toward(int v, int t, int s);
    if (v < t) return (v + s > t) ? t : v + s;
    if (v > t) return (v - s < t) ? t : v - s;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_st[i] = S_IDLE; m_val[i] = 0; m_pv[i] = 0; m_po[i] = 0;
    end
    m_p = 0; m_dv = 0; m_rdy = 0; m_busy = '0;
    exp_q.delete();
  endtask

  task automatic model_cycle();
    int p = m_p;
    int st = m_st[p];
    int v = m_val[p];
    bit pv = m_pv[p];
    bit po = m_po[p];
    bit dn = 0;
    samp_t e;
    case (st)
      S_IDLE: begin
        v = int'(bus.level_start);
        if (pv && po) st = S_ATT;
      end
      S_ATT:
        if (pv) begin
          if (!po) st = S_REL;
        end else begin
          v = toward(v, int'(bus.level_peak), int'(bus.attack_step));
          if (v == int'(bus.level_peak)) st = S_DEC;
        end
      S_DEC:
        if (pv) st = po ? S_ATT : S_REL;
        else begin
          v = toward(v, int'(bus.level_sustain), int'(bus.decay_step));
          if (v == int'(bus.level_sustain)) st = S_SUS;
        end
      S_SUS: begin
        v = int'(bus.level_sustain);
        if (pv) st = po ? S_ATT : S_REL;
      end
      default:
        if (pv && po) st = S_ATT;
        else begin
          v = toward(v, int'(bus.level_floor), int'(bus.release_step));
          if (v == int'(bus.level_floor)) begin st = S_IDLE; dn = 1; end
        end
    endcase
    m_st[p] = st;
    m_val[p] = v;
    m_busy[p] = (st != S_IDLE);
    if (dn) m_dv = p;
    e.vld = 1'b1; e.voice = p[VIDX_W-1:0]; e.value = v[VAL_W-1:0];
    e.busy = m_busy; e.done = dn; e.dv = m_dv[VIDX_W-1:0];
    exp_q.push_back(e);
    m_pv[p] = 0;
    if (bus.ev_valid && m_rdy) begin
      m_pv[bus.ev_voice] = 1;
      m_po[bus.ev_voice] = bus.ev_on;
    end
    m_p = (p + 1) % VOICES;
  endtask

  // One clock: model predicts, DUT advances, scoreboard pops and compares.
  task automatic tick();
    samp_t e, a;
    n_cmp++;
    if (bus.ev_ready !== m_rdy) begin
      n_err++;
      $display("FAIL ev_ready: got %b want %b", bus.ev_ready, m_rdy);
    end
    model_cycle();
    @(posedge clk); #1;
    m_rdy = 1;
    e = exp_q.pop_front();
    a = {bus.out_valid, bus.out_voice, bus.out_value, bus.busy, bus.done, bus.done_voice};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL sample: got vld=%b v=%0d val=%0d busy=%b done=%b/%0d want vld=%b v=%0d val=%0d busy=%b done=%b/%0d",
               a.vld, a.voice, a.value, a.busy, a.done, a.dv, e.vld, e.voice, e.value, e.busy, e.done, e.dv);
    end
  endtask

  // Present an event so that it is accepted on the edge that processes voice at_p.
  task automatic send_event(int voice, bit on, int at_p);
    while (m_p != at_p) tick();
    bus.ev_valid = 1'b1;
    bus.ev_voice = voice[VIDX_W-1:0];
    bus.ev_on    = on;
    tick();
    bus.ev_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_value, bus.busy, bus.done, bus.done_voice, bus.ev_ready, bus.out_voice} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got vld=%b val=%0d busy=%b done=%b rdy=%b want all zero",
               bus.out_valid, bus.out_value, bus.busy, bus.done, bus.ev_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL out_valid_before_first_edge: got %b want 0", bus.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (bus.out_voice !== i % VOICES || bus.out_value !== 0 || bus.busy !== 0 || bus.done !== 0) begin
        n_err++;
        $display("FAIL idle_scan[%0d]: got v=%0d val=%0d busy=%b done=%b want v=%0d val=0 busy=0000 done=0",
                 i, bus.out_voice, bus.out_value, bus.busy, bus.done, i % VOICES);
      end
    end
  endtask

  task automatic test_attack();
    int exp_a [9] = '{0, 300, 600, 900, 1000, 750, 500, 400, 400};
    int k = 0;
    send_event(1, 1'b1, 2);
    for (int c = 0; c < 60 && k < 9; c++) begin
      tick();
      n_cmp++;
      if (bus.out_voice == 1) begin
        if (bus.out_value !== exp_a[k] || bus.busy[1] !== 1'b1 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL attack[%0d]: got val=%0d busy1=%b done=%b want val=%0d busy1=1 done=0",
                   k, bus.out_value, bus.busy[1], bus.done, exp_a[k]);
        end
        k++;
      end else if (bus.out_value !== 0) begin
        n_err++;
        $display("FAIL attack_other_voice: got v=%0d val=%0d want val=0", bus.out_voice, bus.out_value);
      end
    end
    if (k != 9) begin
      n_cmp++; n_err++;
      $display("FAIL attack_timeout: got %0d samples want 9", k);
    end
  endtask

  task automatic test_release();
    int  exp_r [3] = '{400, 200, 0};
    bit  exp_b [3] = '{1, 1, 0};
    bit  exp_d [3] = '{0, 0, 1};
    int  k = 0;
    send_event(1, 1'b0, 2);
    for (int c = 0; c < 30 && k < 3; c++) begin
      tick();
      if (bus.out_voice == 1) begin
        n_cmp++;
        if (bus.out_value !== exp_r[k] || bus.busy[1] !== exp_b[k] || bus.done !== exp_d[k] ||
            (exp_d[k] && bus.done_voice !== 1)) begin
          n_err++;
          $display("FAIL release[%0d]: got val=%0d busy1=%b done=%b dv=%0d want val=%0d busy1=%b done=%b dv=1",
                   k, bus.out_value, bus.busy[1], bus.done, bus.done_voice, exp_r[k], exp_b[k], exp_d[k]);
        end
        k++;
      end
    end
    if (k != 3) begin
      n_cmp++; n_err++;
      $display("FAIL release_timeout: got %0d samples want 3", k);
    end
  endtask

  task automatic test_retrigger_release();
    int  exp_t [4] = '{200, 500, 800, 1000};
    int  k = 0;
    bit  hit = 0;
    send_event(2, 1'b1, 3);
    for (int c = 0; c < 60 && !hit; c++) begin
      tick();
      if (bus.out_voice == 2 && bus.out_value == 400) hit = 1;
    end
    send_event(2, 1'b0, 3);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (bus.out_voice == 2 && bus.out_value == 200) hit = 1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL retrig_reach_200: got no release sample at 200 want one");
    end
    send_event(2, 1'b1, 3);
    for (int c = 0; c < 30 && k < 4; c++) begin
      tick();
      if (bus.out_voice == 2) begin
        n_cmp++;
        if (bus.out_value !== exp_t[k] || bus.busy[2] !== 1'b1) begin
          n_err++;
          $display("FAIL retrig[%0d]: got val=%0d busy2=%b want val=%0d busy2=1",
                   k, bus.out_value, bus.busy[2], exp_t[k]);
        end
        k++;
      end
    end
    if (k != 4) begin
      n_cmp++; n_err++;
      $display("FAIL retrig_timeout: got %0d samples want 4", k);
    end
  endtask

  task automatic test_same_cycle();
    send_event(3, 1'b1, 3);
    n_cmp++;
    if (bus.out_voice !== 3 || bus.busy[3] !== 1'b0 || bus.out_value !== 0) begin
      n_err++;
      $display("FAIL same_cycle_first: got v=%0d busy3=%b val=%0d want v=3 busy3=0 val=0",
               bus.out_voice, bus.busy[3], bus.out_value);
    end
    repeat (4) tick();
    n_cmp++;
    if (bus.out_voice !== 3 || bus.busy[3] !== 1'b1 || bus.out_value !== 0) begin
      n_err++;
      $display("FAIL same_cycle_next: got v=%0d busy3=%b val=%0d want v=3 busy3=1 val=0",
               bus.out_voice, bus.busy[3], bus.out_value);
    end
  endtask

  task automatic test_zero_step();
    int exp_z [2] = '{0, 250};
    int k = 0;
    bus.attack_step = '0;
    send_event(0, 1'b1, 1);
    for (int c = 0; c < 40 && k < 5; c++) begin
      tick();
      if (bus.out_voice == 0) begin
        n_cmp++;
        if (bus.out_value !== 0 || bus.busy[0] !== 1'b1) begin
          n_err++;
          $display("FAIL zero_step_hold[%0d]: got val=%0d busy0=%b want val=0 busy0=1",
                   k, bus.out_value, bus.busy[0]);
        end
        k++;
      end
    end
    bus.level_peak = '0;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      tick();
      if (bus.out_voice == 0) begin
        n_cmp++;
        if (bus.out_value !== exp_z[k] || bus.busy[0] !== 1'b1) begin
          n_err++;
          $display("FAIL zero_step_decay[%0d]: got val=%0d busy0=%b want val=%0d busy0=1",
                   k, bus.out_value, bus.busy[0], exp_z[k]);
        end
        k++;
      end
    end
    if (k != 2) begin
      n_cmp++; n_err++;
      $display("FAIL zero_step_timeout: got %0d samples want 2", k);
    end
    bus.level_peak  = 18'd1000;
    bus.attack_step = 18'd300;
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    send_event(1, 1'b1, 2);
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (bus.out_voice == 1 && bus.out_value == 300) hit = 1;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (!hit || bus.out_valid !== 1'b0 || bus.out_value !== 0 || bus.busy !== 0 || bus.ev_ready !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got hit=%b vld=%b val=%0d busy=%b rdy=%b want hit=1 vld=0 val=0 busy=0000 rdy=0",
               hit, bus.out_valid, bus.out_value, bus.busy, bus.ev_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (bus.out_voice !== i % VOICES || bus.out_value !== 0 || bus.busy !== 0) begin
        n_err++;
        $display("FAIL post_reset_idle[%0d]: got v=%0d val=%0d busy=%b want v=%0d val=0 busy=0000",
                 i, bus.out_voice, bus.out_value, bus.busy, i % VOICES);
      end
    end
  endtask

  initial begin
    bus.ev_valid      = 1'b0;
    bus.ev_voice      = '0;
    bus.ev_on         = 1'b0;
    bus.level_start   = 18'd0;
    bus.level_peak    = 18'd1000;
    bus.level_sustain = 18'd400;
    bus.level_floor   = 18'd0;
    bus.attack_step   = 18'd300;
    bus.decay_step    = 18'd250;
    bus.release_step  = 18'd200;
    model_reset();
    test_reset();
    test_attack();
    test_release();
    test_retrigger_release();
    test_same_cycle();
    test_zero_step();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
